// File: rtl/serial_frame_receive.sv
// serial_frame_receive: frames a UART byte stream (SYNC, payload, optional
// XOR checksum) and publishes the payload only when a complete good frame
// has been received. Inter-byte timeouts and checksum mismatches drop the frame.
module serial_frame_receive #(
  parameter int unsigned PAYLOAD_BYTES  = 84,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter bit          CKSUM_EN       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_byte,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic                       frame_valid,
  output logic                       cksum_err,
  output logic                       timeout_err,
  output logic [15:0]                good_cnt,
  output logic [7:0]                 err_cnt,
  output logic                       busy
);

  localparam int unsigned PW = 8 * PAYLOAD_BYTES;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CKSUM   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   shadow_q, shadow_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      acc_q, acc_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            frame_valid_q, frame_valid_d;
  logic            cksum_err_q, cksum_err_d;
  logic            timeout_err_q, timeout_err_d;
  logic [15:0]     good_cnt_q, good_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            busy_q, busy_d;

  logic [PW-1:0]   shifted_c;
  logic            last_byte_c;
  logic            expired_c;
  logic            commit_c;
  logic            drop_c;

  // Shift helper: newest byte enters at the LSB, oldest falls off the MSB end.
  always_comb begin
    shifted_c   = PW'({shadow_q, rx_byte});
    last_byte_c = (cnt_q == CW'(PAYLOAD_BYTES - 1));
    expired_c   = (timer_q == TW'(TIMEOUT_CYCLES - 1));
  end

  // Next-state and output logic; a received byte always wins over timer expiry.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    payload_d     = payload_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    timer_d       = timer_q;
    frame_valid_d = 1'b0;
    cksum_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    good_cnt_d    = good_cnt_q;
    err_cnt_d     = err_cnt_q;
    commit_c      = 1'b0;
    drop_c        = 1'b0;

    unique case (state_q)
      S_HUNT: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          state_d  = S_PAYLOAD;
          shadow_d = '0;
          cnt_d    = '0;
          acc_d    = '0;
          timer_d  = '0;
        end
      end

      S_PAYLOAD: begin
        if (rx_valid) begin
          shadow_d = shifted_c;
          acc_d    = acc_q ^ rx_byte;
          cnt_d    = cnt_q + CW'(1);
          timer_d  = '0;
          if (last_byte_c) begin
            if (CKSUM_EN) begin
              state_d = S_CKSUM;
            end else begin
              payload_d = shifted_c;
              commit_c  = 1'b1;
            end
          end
        end else if (expired_c) begin
          timeout_err_d = 1'b1;
          drop_c        = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_CKSUM: begin
        if (rx_valid) begin
          timer_d = '0;
          if (rx_byte == acc_q) begin
            payload_d = shadow_q;
            commit_c  = 1'b1;
          end else begin
            cksum_err_d = 1'b1;
            drop_c      = 1'b1;
          end
        end else if (expired_c) begin
          timeout_err_d = 1'b1;
          drop_c        = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d = S_HUNT;
      end
    endcase

    if (commit_c) begin
      frame_valid_d = 1'b1;
      good_cnt_d    = good_cnt_q + 16'd1;
      state_d       = S_HUNT;
    end

    if (drop_c) begin
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      state_d = S_HUNT;
    end

    busy_d = (state_d != S_HUNT);
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_HUNT;
      shadow_q      <= '0;
      payload_q     <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      timer_q       <= '0;
      frame_valid_q <= 1'b0;
      cksum_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      good_cnt_q    <= '0;
      err_cnt_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      payload_q     <= payload_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      timer_q       <= timer_d;
      frame_valid_q <= frame_valid_d;
      cksum_err_q   <= cksum_err_d;
      timeout_err_q <= timeout_err_d;
      good_cnt_q    <= good_cnt_d;
      err_cnt_q     <= err_cnt_d;
      busy_q        <= busy_d;
    end
  end

  assign payload     = payload_q;
  assign frame_valid = frame_valid_q;
  assign cksum_err   = cksum_err_q;
  assign timeout_err = timeout_err_q;
  assign good_cnt    = good_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_serial_frame_receive.sv
// Directed bench for serial_frame_receive: three configurations
// (defaults, short timeout, 4-byte payload without checksum).
module tb_serial_frame_receive;

  localparam int unsigned CW = 672;

  logic        clk;
  logic        rst_n;
  logic        rv [3];
  logic [7:0]  rb [3];

  logic [671:0] p0, p1;
  logic [31:0]  p2;
  logic         fv [3];
  logic         ce [3];
  logic         te [3];
  logic [15:0]  gc [3];
  logic [7:0]   ec [3];
  logic         bz [3];

  int tests_run;
  int fails;

  logic [7:0]   frame_q [$];
  logic [671:0] exp_p;
  logic [7:0]   x;

  serial_frame_receive u_def (
    .clk(clk), .rst_n(rst_n), .rx_valid(rv[0]), .rx_byte(rb[0]),
    .payload(p0), .frame_valid(fv[0]), .cksum_err(ce[0]), .timeout_err(te[0]),
    .good_cnt(gc[0]), .err_cnt(ec[0]), .busy(bz[0])
  );

  serial_frame_receive #(.TIMEOUT_CYCLES(16)) u_to (
    .clk(clk), .rst_n(rst_n), .rx_valid(rv[1]), .rx_byte(rb[1]),
    .payload(p1), .frame_valid(fv[1]), .cksum_err(ce[1]), .timeout_err(te[1]),
    .good_cnt(gc[1]), .err_cnt(ec[1]), .busy(bz[1])
  );

  serial_frame_receive #(.PAYLOAD_BYTES(4), .CKSUM_EN(1'b0)) u_nc (
    .clk(clk), .rst_n(rst_n), .rx_valid(rv[2]), .rx_byte(rb[2]),
    .payload(p2), .frame_valid(fv[2]), .cksum_err(ce[2]), .timeout_err(te[2]),
    .good_cnt(gc[2]), .err_cnt(ec[2]), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [671:0] got, input logic [671:0] exp);
    tests_run++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send every byte of frame_q to DUT d on consecutive cycles.
  task automatic send_q(input int d);
    foreach (frame_q[i]) begin
      rb[d] = frame_q[i];
      rv[d] = 1'b1;
      @(posedge clk);
      #1;
      rv[d] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Payload a correct receiver publishes for frame_q (skips SYNC and checksum).
  function automatic logic [671:0] exp_of_q(input bit has_ck);
    logic [671:0] e;
    int last;
    e    = '0;
    last = frame_q.size() - (has_ck ? 2 : 1);
    for (int i = 1; i <= last; i++) e = {e[663:0], frame_q[i]};
    return e;
  endfunction

  function automatic logic [7:0] xor_of_q();
    logic [7:0] a;
    a = 8'h00;
    for (int i = 1; i < frame_q.size(); i++) a ^= frame_q[i];
    return a;
  endfunction

  initial begin
    tests_run = 0;
    fails     = 0;
    for (int d = 0; d < 3; d++) begin
      rv[d] = 1'b0;
      rb[d] = 8'h00;
    end
    rst_n = 1'b0;
    idle(3);
    chk("rst_payload", CW'(p0), CW'(0));
    chk("rst_fv", CW'(fv[0]), CW'(0));
    chk("rst_good", CW'(gc[0]), CW'(0));
    chk("rst_err", CW'(ec[0]), CW'(0));
    chk("rst_busy", CW'(bz[0]), CW'(0));
    rst_n = 1'b1;
    idle(1);

    // Test 1: default good frame, payload 00..53
    frame_q = {8'hA5};
    for (int i = 0; i < 84; i++) frame_q.push_back(8'(i));
    x = xor_of_q();
    frame_q.push_back(x);
    exp_p = exp_of_q(1'b1);
    send_q(0);
    chk("t1_fv", CW'(fv[0]), CW'(1));
    chk("t1_msb", CW'(p0[671:664]), CW'(8'h00));
    chk("t1_lsb", CW'(p0[7:0]), CW'(8'h53));
    chk("t1_payload", CW'(p0), exp_p);
    chk("t1_good", CW'(gc[0]), CW'(1));
    chk("t1_cerr", CW'(ce[0]), CW'(0));
    chk("t1_busy", CW'(bz[0]), CW'(0));
    idle(1);
    chk("t1_fv_pulse", CW'(fv[0]), CW'(0));

    // Test 2: same frame, inverted checksum
    frame_q[frame_q.size() - 1] = ~x;
    send_q(0);
    chk("t2_cerr", CW'(ce[0]), CW'(1));
    chk("t2_fv", CW'(fv[0]), CW'(0));
    chk("t2_err", CW'(ec[0]), CW'(1));
    chk("t2_payload", CW'(p0), exp_p);
    chk("t2_good", CW'(gc[0]), CW'(1));
    idle(1);
    chk("t2_cerr_pulse", CW'(ce[0]), CW'(0));

    // Test 3: timeout after 10 bytes with TIMEOUT_CYCLES=16
    frame_q = {8'hA5};
    for (int i = 0; i < 10; i++) frame_q.push_back(8'(i + 1));
    send_q(1);
    chk("t3_busy", CW'(bz[1]), CW'(1));
    idle(15);
    chk("t3_te_early", CW'(te[1]), CW'(0));
    chk("t3_busy_early", CW'(bz[1]), CW'(1));
    idle(1);
    chk("t3_te", CW'(te[1]), CW'(1));
    chk("t3_busy_fall", CW'(bz[1]), CW'(0));
    chk("t3_err", CW'(ec[1]), CW'(1));
    chk("t3_fv", CW'(fv[1]), CW'(0));
    chk("t3_payload", CW'(p1), CW'(0));
    frame_q = {8'hA5};
    for (int i = 0; i < 84; i++) frame_q.push_back(8'(i * 3));
    frame_q.push_back(xor_of_q());
    exp_p = exp_of_q(1'b1);
    send_q(1);
    chk("t3_fv_good", CW'(fv[1]), CW'(1));
    chk("t3_payload_good", CW'(p1), exp_p);
    chk("t3_good", CW'(gc[1]), CW'(1));
    chk("t3_err_after", CW'(ec[1]), CW'(1));

    // Test 4: noise before SYNC, SYNC values inside payload
    frame_q = {8'h00, 8'hFF, 8'h5A};
    send_q(1);
    chk("t4_noise_busy", CW'(bz[1]), CW'(0));
    chk("t4_noise_err", CW'(ec[1]), CW'(1));
    frame_q = {8'hA5};
    for (int i = 0; i < 84; i++) frame_q.push_back((i % 5 == 0) ? 8'hA5 : 8'(i));
    frame_q.push_back(xor_of_q());
    exp_p = exp_of_q(1'b1);
    send_q(1);
    chk("t4_fv", CW'(fv[1]), CW'(1));
    chk("t4_payload", CW'(p1), exp_p);
    chk("t4_good", CW'(gc[1]), CW'(2));

    // Byte arriving on the would-be expiry cycle is accepted
    frame_q = {8'hA5};
    send_q(1);
    idle(15);
    frame_q = {8'h11};
    send_q(1);
    chk("prio_te", CW'(te[1]), CW'(0));
    chk("prio_busy", CW'(bz[1]), CW'(1));
    idle(16);
    chk("prio_te_late", CW'(te[1]), CW'(1));
    chk("prio_err", CW'(ec[1]), CW'(2));
    chk("prio_payload", CW'(p1), exp_p);

    // Test 5: no checksum, 4-byte payload back to back
    frame_q = {8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_q(2);
    chk("t5_fv", CW'(fv[2]), CW'(1));
    chk("t5_payload", CW'(p2), CW'(32'hDEADBEEF));
    chk("t5_good", CW'(gc[2]), CW'(1));
    chk("t5_busy", CW'(bz[2]), CW'(0));
    idle(1);
    chk("t5_fv_pulse", CW'(fv[2]), CW'(0));
    chk("t5_payload_hold", CW'(p2), CW'(32'hDEADBEEF));

    // Test 6: reset mid-payload, then good frame, then error saturation
    frame_q = {8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_q(1);
    chk("t6_busy", CW'(bz[1]), CW'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_payload", CW'(p1), CW'(0));
    chk("t6_rst_good", CW'(gc[1]), CW'(0));
    chk("t6_rst_err", CW'(ec[1]), CW'(0));
    chk("t6_rst_busy", CW'(bz[1]), CW'(0));
    chk("t6_rst_p2", CW'(p2), CW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    frame_q = {8'hA5};
    for (int i = 0; i < 84; i++) frame_q.push_back(8'(i + 7));
    frame_q.push_back(xor_of_q());
    exp_p = exp_of_q(1'b1);
    send_q(1);
    chk("t6_fv", CW'(fv[1]), CW'(1));
    chk("t6_payload", CW'(p1), exp_p);
    chk("t6_good", CW'(gc[1]), CW'(1));
    chk("t6_err", CW'(ec[1]), CW'(0));
    frame_q = {8'hA5};
    repeat (300) begin
      send_q(1);
      idle(16);
    end
    chk("t6_err_sat", CW'(ec[1]), CW'(8'hFF));
    chk("t6_good_after", CW'(gc[1]), CW'(1));
    chk("t6_payload_after", CW'(p1), exp_p);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
